// File: rtl/ucaspian_pkg.sv
// ---------------------------------------------------------------------------
// ucaspian_pkg
// Shared types for the uCaspian timestep scheduler: host command opcodes,
// scheduler FSM states and the default step-count width.
// ---------------------------------------------------------------------------
package ucaspian_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   // Host command opcodes (encoding is part of the packet format)
   typedef enum logic [1:0] {
      OP_RUN          = 2'd0,
      OP_CLEAR_ACT    = 2'd1,
      OP_CLEAR_CONFIG = 2'd2,
      OP_STATUS       = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_PULSE  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_WAIT   = 3'd4,
      ST_RESP   = 3'd5
   } state_e;

endpackage

// File: rtl/ucaspian_all_done.sv
// ---------------------------------------------------------------------------
// ucaspian_all_done
// Registered AND-reduce of per-unit done flags with a hold-off window.
// A start pulse (re)arms the window: for holdoff_i sampled cycles after it
// the inputs are ignored, afterwards done_o follows &in_i one cycle late.
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start_i     arm the hold-off window (clears done_o)
//   holdoff_i   number of sampled cycles to ignore after start_i
//   in_i        per-unit done flags
//   done_o      all units done, registered
// ---------------------------------------------------------------------------
module ucaspian_all_done
   import ucaspian_pkg::*;
#(
   parameter int unsigned N      = 3,
   parameter int unsigned HOLD_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [HOLD_W-1:0] holdoff_i,
   input  logic [N-1:0]      in_i,
   output logic              done_o
);

   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   // Hold-off countdown; done only sampled once the window has drained
   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (start_i) begin
         cnt_d = holdoff_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - HOLD_W'(1);
      end else begin
         done_d = &in_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/ucaspian_step_ctrl.sv
// ---------------------------------------------------------------------------
// ucaspian_step_ctrl
// Timestep scheduler: accepts host commands (RUN n steps, CLEAR_ACT,
// CLEAR_CONFIG, STATUS), sequences enable/next_step/clear lines to the
// compute units, collects their done flags and returns one response per
// command. All outputs are registered (decoded from the next state).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_op/steps/vld/rdy  host command channel
//   halt                stop a RUN after the step in progress completes
//   enable, next_step   unit enable, one-cycle step-start pulse
//   clear_act/config    clear request levels
//   step_done/clear_done  per-unit completion flags
//   resp_vld/rdy/op/count response channel
//   total_steps         steps executed since last clear/reset (wrapping)
//   busy                scheduler not idle
// ---------------------------------------------------------------------------
module ucaspian_step_ctrl
   import ucaspian_pkg::*;
#(
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned SETTLE    = 2,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           cmd_op,
   input  logic [CNT_W-1:0]     cmd_steps,
   input  logic                 cmd_vld,
   output logic                 cmd_rdy,
   input  logic                 halt,
   output logic                 enable,
   output logic                 next_step,
   output logic                 clear_act,
   output logic                 clear_config,
   input  logic [NUM_UNITS-1:0] step_done,
   input  logic [NUM_UNITS-1:0] clear_done,
   output logic                 resp_vld,
   input  logic                 resp_rdy,
   output logic [1:0]           resp_op,
   output logic [CNT_W-1:0]     resp_count,
   output logic [CNT_W-1:0]     total_steps,
   output logic                 busy
);

   localparam int unsigned HOLD_W = $clog2(SETTLE + 2);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [HOLD_W-1:0] settle_q, settle_d;
   logic [1:0]        resp_op_q, resp_op_d;
   logic [CNT_W-1:0]  resp_count_q, resp_count_d;
   logic              cmd_rdy_q, cmd_rdy_d;
   logic              enable_q, enable_d;
   logic              next_step_q, next_step_d;
   logic              clear_act_q, clear_act_d;
   logic              clear_cfg_q, clear_cfg_d;
   logic              resp_vld_q, resp_vld_d;
   logic              busy_q, busy_d;

   logic step_start, clr_start;
   logic step_all, clr_all;

   // Step detector re-arms on every pulse so the units' stale step_done drains
   assign step_start = (state_d == ST_PULSE);
   // Clear detector ignores the first cycle the clear line is up
   assign clr_start  = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

   ucaspian_all_done #(.N(NUM_UNITS), .HOLD_W(HOLD_W)) u_step_done (
      .clk       (clk),
      .reset     (reset),
      .start_i   (step_start),
      .holdoff_i (HOLD_W'(SETTLE)),
      .in_i      (step_done),
      .done_o    (step_all)
   );

   ucaspian_all_done #(.N(NUM_UNITS), .HOLD_W(HOLD_W)) u_clear_done (
      .clk       (clk),
      .reset     (reset),
      .start_i   (clr_start),
      .holdoff_i (HOLD_W'(1)),
      .in_i      (clear_done),
      .done_o    (clr_all)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      remaining_d  = remaining_q;
      run_cnt_d    = run_cnt_q;
      total_d      = total_q;
      settle_d     = settle_q;
      resp_op_d    = resp_op_q;
      resp_count_d = resp_count_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_vld && cmd_rdy_q) begin
               op_d        = op_e'(cmd_op);
               remaining_d = cmd_steps;
               run_cnt_d   = '0;
               case (op_e'(cmd_op))
                  OP_CLEAR_ACT, OP_CLEAR_CONFIG: state_d = ST_CLEAR;
                  OP_STATUS: begin
                     state_d      = ST_RESP;
                     resp_op_d    = cmd_op;
                     resp_count_d = total_q;
                  end
                  default: begin
                     if (cmd_steps == '0) begin
                        state_d      = ST_RESP;
                        resp_op_d    = cmd_op;
                        resp_count_d = '0;
                     end else begin
                        state_d = ST_PULSE;
                     end
                  end
               endcase
            end
         end
         ST_CLEAR: begin
            if (clr_all) begin
               total_d      = '0;
               state_d      = ST_RESP;
               resp_op_d    = op_q;
               resp_count_d = '0;
            end
         end
         ST_PULSE: begin
            settle_d = HOLD_W'(SETTLE);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            settle_d = settle_q - HOLD_W'(1);
            if (settle_d == '0) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (step_all) begin
               run_cnt_d   = run_cnt_q + CNT_W'(1);
               total_d     = total_q + CNT_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
               // halt only takes effect at a step boundary
               if (remaining_q == CNT_W'(1) || halt) begin
                  state_d      = ST_RESP;
                  resp_op_d    = op_q;
                  resp_count_d = run_cnt_q + CNT_W'(1);
               end else begin
                  state_d = ST_PULSE;
               end
            end
         end
         ST_RESP: begin
            if (resp_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_rdy_d   = (state_d == ST_IDLE);
      enable_d    = (state_d == ST_PULSE) || (state_d == ST_SETTLE) ||
                    (state_d == ST_WAIT);
      next_step_d = (state_d == ST_PULSE);
      clear_act_d = (state_d == ST_CLEAR) && (op_d == OP_CLEAR_ACT);
      clear_cfg_d = (state_d == ST_CLEAR) && (op_d == OP_CLEAR_CONFIG);
      resp_vld_d  = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_RUN;
         remaining_q  <= '0;
         run_cnt_q    <= '0;
         total_q      <= '0;
         settle_q     <= '0;
         resp_op_q    <= '0;
         resp_count_q <= '0;
         cmd_rdy_q    <= 1'b1;
         enable_q     <= 1'b0;
         next_step_q  <= 1'b0;
         clear_act_q  <= 1'b0;
         clear_cfg_q  <= 1'b0;
         resp_vld_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         remaining_q  <= remaining_d;
         run_cnt_q    <= run_cnt_d;
         total_q      <= total_d;
         settle_q     <= settle_d;
         resp_op_q    <= resp_op_d;
         resp_count_q <= resp_count_d;
         cmd_rdy_q    <= cmd_rdy_d;
         enable_q     <= enable_d;
         next_step_q  <= next_step_d;
         clear_act_q  <= clear_act_d;
         clear_cfg_q  <= clear_cfg_d;
         resp_vld_q   <= resp_vld_d;
         busy_q       <= busy_d;
      end
   end

   assign cmd_rdy      = cmd_rdy_q;
   assign enable       = enable_q;
   assign next_step    = next_step_q;
   assign clear_act    = clear_act_q;
   assign clear_config = clear_cfg_q;
   assign resp_vld     = resp_vld_q;
   assign resp_op      = resp_op_q;
   assign resp_count   = resp_count_q;
   assign total_steps  = total_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ucaspian_step_ctrl
// Self-checking bench: directed scenarios plus randomized commands, unit
// responders with random latency, and a command-level reference model
// (expected step count and running total modulo 2^CNT_W).
// ---------------------------------------------------------------------------
module tb_ucaspian_step_ctrl;

   localparam int unsigned NU  = 3;
   localparam int unsigned ST  = 2;
   localparam int unsigned CW  = 4;
   localparam int unsigned MOD = 1 << CW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    cmd_op = '0;
   logic [CW-1:0] cmd_steps = '0;
   logic          cmd_vld = 1'b0;
   logic          cmd_rdy;
   logic          halt = 1'b0;
   logic          enable, next_step, clear_act, clear_config;
   logic [NU-1:0] step_done = '0;
   logic [NU-1:0] clear_done = '0;
   logic          resp_vld;
   logic          resp_rdy = 1'b0;
   logic [1:0]    resp_op;
   logic [CW-1:0] resp_count, total_steps;
   logic          busy;

   ucaspian_step_ctrl #(.NUM_UNITS(NU), .SETTLE(ST), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_op       (cmd_op),
      .cmd_steps    (cmd_steps),
      .cmd_vld      (cmd_vld),
      .cmd_rdy      (cmd_rdy),
      .halt         (halt),
      .enable       (enable),
      .next_step    (next_step),
      .clear_act    (clear_act),
      .clear_config (clear_config),
      .step_done    (step_done),
      .clear_done   (clear_done),
      .resp_vld     (resp_vld),
      .resp_rdy     (resp_rdy),
      .resp_op      (resp_op),
      .resp_count   (resp_count),
      .total_steps  (total_steps),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Unit responder and protocol monitor (runs on falling edges)
   int cyc = 0, pulse_cnt = 0, last_pulse = -1, sd_cnt = 0;
   int gap_bad = 0, ns_clr_viol = 0, en_viol = 0;
   int clr_act_cyc = 0, clr_cfg_cyc = 0;
   int lat_lo = 5, lat_hi = 5;
   bit stuck = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            sd_cnt    = 0;
            step_done = '0;
         end else begin
            if (next_step) begin
               pulse_cnt++;
               if (last_pulse >= 0) begin
                  if (stuck ? (cyc - last_pulse != int'(ST) + 2)
                            : (cyc - last_pulse < int'(ST) + 2)) gap_bad++;
               end
               last_pulse = cyc;
               if (clear_act || clear_config) ns_clr_viol++;
               if (!enable) en_viol++;
               if (!stuck) begin
                  step_done = '0;
                  sd_cnt    = $urandom_range(lat_hi, lat_lo);
               end
            end else if (sd_cnt > 0) begin
               sd_cnt--;
               step_done = (sd_cnt == 0) ? 3'b111 : (3'($urandom) & 3'b011);
            end
            if (stuck) step_done = '1;
            if (clear_act) clr_act_cyc++;
            if (clear_config) clr_cfg_cyc++;
         end
      end
   end

   int total_model = 0;

   // Issue one command, collect its response and compare against the model
   task automatic run_cmd(input logic [1:0] op, input int steps, input int halt_at,
                          input int stall, input bit junk, input int clr_delay);
      int            exp_cnt, last_hi, stall_bad;
      bit            got_resp, is_clr;
      logic [CW-1:0] held;
      is_clr = (op == 2'd1) || (op == 2'd2);
      @(negedge clk);
      check("rdy_idle", cmd_rdy, 1);
      pulse_cnt   = 0;
      last_pulse  = -1;
      clr_act_cyc = 0;
      clr_cfg_cyc = 0;
      cmd_op      = op;
      cmd_steps   = CW'(steps);
      cmd_vld     = 1'b1;
      clear_done  = is_clr ? 3'b111 : 3'($urandom);   // stale high on clears
      @(negedge clk);
      cmd_vld = junk;
      if (junk) begin
         cmd_op    = 2'($urandom);
         cmd_steps = CW'($urandom);
      end
      got_resp = 1'b0;
      last_hi  = -1;
      for (int i = 0; i < 1000 && !got_resp; i++) begin
         @(negedge clk);
         if (clear_act || clear_config) last_hi = i;
         if (is_clr) clear_done = (i >= clr_delay) ? 3'b111 : 3'b011;
         if (halt_at > 0 && pulse_cnt >= halt_at) halt = 1'b1;
         if (resp_vld) got_resp = 1'b1;
      end
      cmd_vld = 1'b0;
      check("resp_seen", got_resp, 1);

      case (op)
         2'd0: begin
            exp_cnt     = (halt_at > 0 && halt_at < steps) ? halt_at : steps;
            total_model = (total_model + exp_cnt) % MOD;
         end
         2'd1, 2'd2: begin
            exp_cnt     = 0;
            total_model = 0;
         end
         default: exp_cnt = total_model;
      endcase
      check("resp_op", resp_op, op);
      check("resp_count", resp_count, exp_cnt);
      check("total_steps", total_steps, total_model);
      check("pulses", pulse_cnt, (op == 2'd0) ? exp_cnt : 0);
      if (is_clr) begin
         check("clr_hold", last_hi >= clr_delay, 1);
         check("clr_drop", last_hi <= clr_delay + 1, 1);
         check("clr_line", (op == 2'd1) ? clr_cfg_cyc : clr_act_cyc, 0);
      end

      held      = resp_count;
      stall_bad = 0;
      repeat (stall) begin
         @(negedge clk);
         if (!resp_vld || resp_count !== held || cmd_rdy || !busy) stall_bad++;
      end
      if (stall > 0) check("stall_hold", stall_bad, 0);
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
      halt     = 1'b0;
      check("post_resp", {cmd_rdy, busy, resp_vld, enable}, 4'b1000);
   endtask

   initial begin
      int rop, rsteps, rhalt, idle_bad;
      repeat (3) @(negedge clk);
      check("rst_cmd_rdy", cmd_rdy, 1);
      check("rst_ctl", {enable, next_step, clear_act, clear_config, resp_vld, busy}, 0);
      check("rst_resp", {resp_op, resp_count}, 0);
      check("rst_total", total_steps, 0);
      reset = 1'b0;

      // RUN 3 with fixed 5-cycle unit latency
      stuck = 1'b0; lat_lo = 5; lat_hi = 5;
      run_cmd(2'd0, 3, 0, 0, 1'b0, 0);
      // RUN 4 with step_done stuck high: pulse spacing must be exactly SETTLE+2
      stuck = 1'b1;
      run_cmd(2'd0, 4, 0, 0, 1'b0, 0);
      stuck = 1'b0; lat_lo = 2; lat_hi = 6;
      // RUN 10 halted during step 2
      run_cmd(2'd0, 10, 2, 0, 1'b1, 0);
      // CLEAR_CONFIG with partial clear_done for 20 cycles
      run_cmd(2'd2, 0, 0, 0, 1'b0, 20);
      // zero-step RUN and STATUS with stalled response
      run_cmd(2'd0, 0, 0, 5, 1'b0, 0);
      run_cmd(2'd3, 0, 0, 5, 1'b1, 0);
      // total_steps wrap
      lat_lo = 1; lat_hi = 1;
      run_cmd(2'd0, 15, 0, 0, 1'b0, 0);
      run_cmd(2'd0, 2, 0, 0, 1'b0, 0);
      run_cmd(2'd3, 0, 0, 0, 1'b0, 0);

      // randomized commands
      for (int k = 0; k < 30; k++) begin
         rop    = int'($urandom_range(3, 0));
         rsteps = int'($urandom_range(MOD - 1, 0));
         rhalt  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(MOD - 1, 1)) : 0;
         stuck  = ($urandom_range(3, 0) == 0);
         lat_lo = 1;
         lat_hi = int'($urandom_range(7, 1));
         run_cmd(2'(rop), rsteps, rhalt, int'($urandom_range(3, 0)),
                 1'($urandom), int'($urandom_range(8, 1)));
      end

      // reset while a step is in its WAIT phase
      stuck = 1'b0; lat_lo = 6; lat_hi = 6;
      @(negedge clk);
      pulse_cnt  = 0;
      last_pulse = -1;
      cmd_op     = 2'd0;
      cmd_steps  = CW'(10);
      cmd_vld    = 1'b1;
      @(negedge clk);
      cmd_vld = 1'b0;
      for (int i = 0; i < 200 && pulse_cnt < 2; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("pre_rst_enable", enable, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_cmd_rdy", cmd_rdy, 1);
      check("mid_rst_ctl", {enable, next_step, clear_act, clear_config, resp_vld, busy}, 0);
      check("mid_rst_vals", {resp_op, resp_count, total_steps}, 0);
      total_model = 0;
      idle_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (resp_vld || busy || next_step) idle_bad++;
      end
      check("mid_rst_quiet", idle_bad, 0);
      run_cmd(2'd3, 0, 0, 0, 1'b0, 0);

      check("pulse_gap", gap_bad, 0);
      check("pulse_during_clear", ns_clr_viol, 0);
      check("pulse_without_enable", en_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
